mpx_hilo: RTL and testbench
===========================

Name: mpx_hilo

Overview:
- Consumer end of the multiply/divide writeback interface.
- Holds the architectural HI/LO registers and absorbs writebacks from the divider and multiplier.
- Executes MFHI/MFLO/MTHI/MTLO and interlocks every HI/LO-touching instruction while a multiply or divide is outstanding.
- Sits beside the issue stage; its accept output gates issue of HI/LO instructions.

Parameters:
- None. Opcode fields and function codes come from the shared MPX definitions: INST_R [31:26], FUNC_R [5:0], SPECIAL=6'h00, MFHI=6'h10, MTHI=6'h11, MFLO=6'h12, MTLO=6'h13, MULT=6'h18, MULTU=6'h19, DIV=6'h1a, DIVU=6'h1b.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- opcode_valid_i  in  1  issue slot holds an instruction
- opcode_opcode_i  in  32  instruction word
- opcode_rd_idx_i  in  5  destination register (MFHI/MFLO)
- opcode_rs_operand_i  in  32  rs value (MTHI/MTLO)
- opcode_accept_o  out  1  instruction in slot accepted this cycle
- div_writeback_valid_i  in  1  divider result strobe
- div_writeback_hi_i  in  32  remainder
- div_writeback_lo_i  in  32  quotient
- mul_writeback_valid_i  in  1  multiplier result strobe
- mul_writeback_hi_i  in  32  product high word
- mul_writeback_lo_i  in  32  product low word
- writeback_valid_o  out  1  MFHI/MFLO result valid
- writeback_rd_idx_o  out  5  destination index
- writeback_value_o  out  32  HI or LO value
- hilo_busy_o  out  1  a multiply or divide is outstanding

Behaviour:
- Reset (async, any state):
  - State=IDLE; hi_q=lo_q=0.
  - writeback_valid_o=0, writeback_rd_idx_o=0, writeback_value_o=0.
  - hilo_busy_o=0.
  - Any in-flight operation is forgotten; a later stray writeback is handled by the IDLE rules below.
- Decode: hilo_inst = SPECIAL && FUNC in {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU}.
- Accept rule (combinational from registered state):
  - opcode_accept_o = !hilo_inst || state==IDLE.
  - Non-HI/LO instructions are always accepted and ignored.
  - A stalled instruction must be held by issue until accepted.
- State machine: IDLE, WAIT_DIV, WAIT_MUL.
  - IDLE + accepted DIV/DIVU -> WAIT_DIV.
  - IDLE + accepted MULT/MULTU -> WAIT_MUL.
  - WAIT_DIV + div_writeback_valid_i -> IDLE; hi_q/lo_q <= div hi/lo.
  - WAIT_MUL + mul_writeback_valid_i -> IDLE; hi_q/lo_q <= mul hi/lo.
  - A mismatched-source writeback in a WAIT state is ignored and the state is unchanged.
  - hilo_busy_o = (state != IDLE), registered.
- Writeback in IDLE (no outstanding op): hi_q/lo_q are updated anyway.
  - If div and mul strobe together, div wins.
  - An MTHI/MTLO accepted the same cycle wins for the register it writes.
- MTHI/MTLO: on accept, hi_q or lo_q <= opcode_rs_operand_i at the next edge. No writeback output.
- MFHI/MFLO: on accept, the next edge sets:
  - writeback_valid_o=1
  - writeback_rd_idx_o=opcode_rd_idx_i
  - writeback_value_o = hi_q or lo_q (value before that edge)
  - Latency is 1 cycle; writeback_valid_o is a single-cycle pulse per accepted MF instruction.
  - Back-to-back MF instructions give back-to-back pulses.
  - rd_idx/value hold their last values when valid is 0.
- Writeback and a stalled MF in the same cycle: the MF stays stalled (accept=0) that cycle. It is accepted next cycle and returns the new result, so there is no stale read.
- MTHI then MFHI on consecutive cycles: MFHI returns the MTHI value (register updated at the intervening edge).
- New MULT/DIV while IDLE: accepted the same cycle the previous writeback is absorbed only if the state has already returned to IDLE. There is no overlap; at most one operation is ever outstanding.

Test Plan:
- Reset, then MTHI rs=0x12345678 followed by MFHI rd=3 -> MFHI accepted; next cycle writeback_valid_o=1, rd_idx=3, value=0x12345678.
- DIV issued, then MFLO held 10 cycles; div writeback hi=0x1, lo=0x3 on cycle 10 -> accept low cycles 1-10, high cycle 11; writeback value=0x3 on cycle 12; hilo_busy_o high throughout the wait.
- MULT outstanding, spurious div_writeback_valid_i hi=0xDEAD lo=0xBEEF -> ignored, state stays WAIT_MUL; mul writeback 0x0/0x6 later -> MFLO returns 0x6.
- MTLO accepted in IDLE the same cycle as a stray mul writeback lo=0x55 with MTLO rs=0xAA -> lo_q=0xAA, hi_q=mul hi.
- Async reset asserted mid WAIT_DIV -> accept=1, busy=0, HI=LO=0 immediately; a later div writeback in IDLE updates HI/LO, verified via MFHI.
- Non-HI/LO instruction (ADDU) issued during WAIT_DIV -> opcode_accept_o=1, no writeback pulse, state unchanged.

Source files
------------

// File: rtl/mpx_hilo.sv
// HI/LO register file at the consumer end of the multiply/divide writeback path.
// Executes MFHI/MFLO/MTHI/MTLO and stalls HI/LO instructions while a MULT or DIV is outstanding.
module mpx_hilo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [31:0] opcode_rs_operand_i,
    output logic        opcode_accept_o,
    input  logic        div_writeback_valid_i,
    input  logic [31:0] div_writeback_hi_i,
    input  logic [31:0] div_writeback_lo_i,
    input  logic        mul_writeback_valid_i,
    input  logic [31:0] mul_writeback_hi_i,
    input  logic [31:0] mul_writeback_lo_i,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_idx_o,
    output logic [31:0] writeback_value_o,
    output logic        hilo_busy_o
);

    localparam logic [5:0] SPECIAL = 6'h00;
    localparam logic [5:0] MFHI    = 6'h10;
    localparam logic [5:0] MTHI    = 6'h11;
    localparam logic [5:0] MFLO    = 6'h12;
    localparam logic [5:0] MTLO    = 6'h13;
    localparam logic [5:0] MULT    = 6'h18;
    localparam logic [5:0] MULTU   = 6'h19;
    localparam logic [5:0] DIV     = 6'h1a;
    localparam logic [5:0] DIVU    = 6'h1b;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DIV = 2'd1,
        WAIT_MUL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_idx_q, wb_rd_idx_d;
    logic [31:0] wb_value_q, wb_value_d;

    logic [5:0]  inst_r;
    logic [5:0]  func_r;
    logic        hilo_inst;
    logic        issue_fire;
    logic        unused_opcode_bits;

    assign inst_r             = opcode_opcode_i[31:26];
    assign func_r             = opcode_opcode_i[5:0];
    assign unused_opcode_bits = ^opcode_opcode_i[25:6];

    always_comb begin
        hilo_inst = 1'b0;
        if (inst_r == SPECIAL) begin
            case (func_r)
                MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU: hilo_inst = 1'b1;
                default:                                        hilo_inst = 1'b0;
            endcase
        end
    end

    // Only the registered state gates acceptance, so a writeback landing this cycle cannot
    // release a stalled MF early and hand it a stale HI/LO value.
    assign opcode_accept_o = !hilo_inst || (state_q == IDLE);
    assign issue_fire      = opcode_valid_i && hilo_inst && opcode_accept_o;

    always_comb begin
        // NOTE: every next-state signal is defaulted up front so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        wb_valid_d  = 1'b0;
        wb_rd_idx_d = wb_rd_idx_q;
        wb_value_d  = wb_value_q;

        case (state_q)
            IDLE: begin
                if (div_writeback_valid_i) begin
                    hi_d = div_writeback_hi_i;
                    lo_d = div_writeback_lo_i;
                end else if (mul_writeback_valid_i) begin
                    hi_d = mul_writeback_hi_i;
                    lo_d = mul_writeback_lo_i;
                end
            end
            WAIT_DIV: begin
                if (div_writeback_valid_i) begin
                    hi_d    = div_writeback_hi_i;
                    lo_d    = div_writeback_lo_i;
                    state_d = IDLE;
                end
            end
            WAIT_MUL: begin
                if (mul_writeback_valid_i) begin
                    hi_d    = mul_writeback_hi_i;
                    lo_d    = mul_writeback_lo_i;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Issue can only fire in IDLE, so MTHI/MTLO override any stray writeback above.
        if (issue_fire) begin
            case (func_r)
                MTHI: hi_d = opcode_rs_operand_i;
                MTLO: lo_d = opcode_rs_operand_i;
                MFHI: begin
                    wb_valid_d  = 1'b1;
                    wb_rd_idx_d = opcode_rd_idx_i;
                    wb_value_d  = hi_q;
                end
                MFLO: begin
                    wb_valid_d  = 1'b1;
                    wb_rd_idx_d = opcode_rd_idx_i;
                    wb_value_d  = lo_q;
                end
                MULT, MULTU: state_d = WAIT_MUL;
                DIV, DIVU:   state_d = WAIT_DIV;
                default:     ;
            endcase
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_idx_q <= '0;
            wb_value_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_idx_q <= wb_rd_idx_d;
            wb_value_q  <= wb_value_d;
        end
    end

    assign writeback_valid_o  = wb_valid_q;
    assign writeback_rd_idx_o = wb_rd_idx_q;
    assign writeback_value_o  = wb_value_q;
    assign hilo_busy_o        = busy_q;

endmodule

// File: tb/tb_mpx_hilo.sv
// Testbench for mpx_hilo: directed scenarios plus randomized traffic checked
// against an instruction-level model of the HI/LO unit.
module tb_mpx_hilo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        opcode_valid_i = 1'b0;
    logic [31:0] opcode_opcode_i = '0;
    logic [4:0]  opcode_rd_idx_i = '0;
    logic [31:0] opcode_rs_operand_i = '0;
    logic        opcode_accept_o;
    logic        div_writeback_valid_i = 1'b0;
    logic [31:0] div_writeback_hi_i = '0;
    logic [31:0] div_writeback_lo_i = '0;
    logic        mul_writeback_valid_i = 1'b0;
    logic [31:0] mul_writeback_hi_i = '0;
    logic [31:0] mul_writeback_lo_i = '0;
    logic        writeback_valid_o;
    logic [4:0]  writeback_rd_idx_o;
    logic [31:0] writeback_value_o;
    logic        hilo_busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    mpx_hilo dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .opcode_valid_i        (opcode_valid_i),
        .opcode_opcode_i       (opcode_opcode_i),
        .opcode_rd_idx_i       (opcode_rd_idx_i),
        .opcode_rs_operand_i   (opcode_rs_operand_i),
        .opcode_accept_o       (opcode_accept_o),
        .div_writeback_valid_i (div_writeback_valid_i),
        .div_writeback_hi_i    (div_writeback_hi_i),
        .div_writeback_lo_i    (div_writeback_lo_i),
        .mul_writeback_valid_i (mul_writeback_valid_i),
        .mul_writeback_hi_i    (mul_writeback_hi_i),
        .mul_writeback_lo_i    (mul_writeback_lo_i),
        .writeback_valid_o     (writeback_valid_o),
        .writeback_rd_idx_o    (writeback_rd_idx_o),
        .writeback_value_o     (writeback_value_o),
        .hilo_busy_o           (hilo_busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
    localparam logic [5:0] F_ADDU = 6'h21;

    // Reference model: what is pending (0 none, 1 divide, 2 multiply) plus architectural HI/LO.
    int          m_pend = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_wbv = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_val = '0;

    function automatic bit is_hilo(input logic [31:0] op);
        logic [5:0] f;
        f = op[5:0];
        return (op[31:26] == 6'h00) && (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
    endfunction

    function automatic bit exp_accept();
        return !is_hilo(opcode_opcode_i) || (m_pend == 0);
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pend = 0; m_hi = '0; m_lo = '0; m_wbv = 1'b0; m_rd = '0; m_val = '0;
        end else begin
            logic [31:0] old_hi, old_lo;
            logic [5:0]  f;
            bit          fire;
            old_hi = m_hi;
            old_lo = m_lo;
            f      = opcode_opcode_i[5:0];
            fire   = opcode_valid_i && is_hilo(opcode_opcode_i) && (m_pend == 0);
            m_wbv  = 1'b0;
            if (div_writeback_valid_i && m_pend != 2) begin
                m_hi = div_writeback_hi_i; m_lo = div_writeback_lo_i; m_pend = 0;
            end else if (mul_writeback_valid_i && m_pend != 1) begin
                m_hi = mul_writeback_hi_i; m_lo = mul_writeback_lo_i; m_pend = 0;
            end
            if (fire) begin
                if (f == F_MTHI) m_hi = opcode_rs_operand_i;
                if (f == F_MTLO) m_lo = opcode_rs_operand_i;
                if (f == F_MFHI || f == F_MFLO) begin
                    m_wbv = 1'b1;
                    m_rd  = opcode_rd_idx_i;
                    m_val = (f == F_MFHI) ? old_hi : old_lo;
                end
                if (f == F_MULT || f == F_MULTU) m_pend = 2;
                if (f == F_DIV || f == F_DIVU) m_pend = 1;
            end
        end
    end

    task automatic drive_op(input bit v, input logic [5:0] f, input logic [4:0] rd, input logic [31:0] rs);
        logic [31:0] r;
        r = $urandom();
        opcode_valid_i      = v;
        opcode_opcode_i     = {6'h00, r[25:6], f};
        opcode_rd_idx_i     = rd;
        opcode_rs_operand_i = rs;
    endtask

    task automatic drive_wb(input bit dv, input logic [31:0] dh, input logic [31:0] dl,
                            input bit mv, input logic [31:0] mh, input logic [31:0] ml);
        div_writeback_valid_i = dv; div_writeback_hi_i = dh; div_writeback_lo_i = dl;
        mul_writeback_valid_i = mv; mul_writeback_hi_i = mh; mul_writeback_lo_i = ml;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        drive_op(1'b1, F_MFHI, 5'd9, 32'h0);
        #1;
        n_checks++; if (opcode_accept_o !== 1'b1) begin n_fail++; $display("FAIL reset_accept: got %b want 1", opcode_accept_o); end
        n_checks++; if (hilo_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", hilo_busy_o); end
        n_checks++; if ({writeback_valid_o, writeback_rd_idx_o, writeback_value_o} !== 38'h0) begin
            n_fail++; $display("FAIL reset_wb: got v=%b rd=%0d val=%h want all zero", writeback_valid_o, writeback_rd_idx_o, writeback_value_o); end
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_mthi_mfhi();
        drive_op(1'b1, F_MTHI, 5'd0, 32'h12345678);
        #1;
        n_checks++; if (opcode_accept_o !== 1'b1) begin n_fail++; $display("FAIL mthi_accept: got %b want 1", opcode_accept_o); end
        tick();
        drive_op(1'b1, F_MFHI, 5'd3, 32'h0);
        #1;
        n_checks++; if (opcode_accept_o !== 1'b1) begin n_fail++; $display("FAIL mfhi_accept: got %b want 1", opcode_accept_o); end
        n_checks++; if (writeback_valid_o !== 1'b0) begin n_fail++; $display("FAIL mthi_no_wb: got %b want 0", writeback_valid_o); end
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_rd_idx_o, writeback_value_o} !== {1'b1, 5'd3, 32'h12345678}) begin
            n_fail++; $display("FAIL mfhi_result: got v=%b rd=%0d val=%h want v=1 rd=3 val=12345678", writeback_valid_o, writeback_rd_idx_o, writeback_value_o); end
        tick();
        n_checks++; if ({writeback_valid_o, writeback_rd_idx_o, writeback_value_o} !== {1'b0, 5'd3, 32'h12345678}) begin
            n_fail++; $display("FAIL mfhi_pulse_hold: got v=%b rd=%0d val=%h want v=0 rd=3 val=12345678", writeback_valid_o, writeback_rd_idx_o, writeback_value_o); end
    endtask

    task automatic test_div_stall();
        int stalls;
        stalls = 0;
        drive_op(1'b1, F_DIV, 5'd0, 32'h0);
        tick();
        drive_op(1'b1, F_MFLO, 5'd7, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) drive_wb(1'b1, 32'h1, 32'h3, 1'b0, 32'h0, 32'h0);
            #1;
            if (opcode_accept_o === 1'b0 && hilo_busy_o === 1'b1) stalls++;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        n_checks++; if (stalls != 10) begin n_fail++; $display("FAIL div_stall: stalled+busy cycles got %0d want 10", stalls); end
        drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++; if ({opcode_accept_o, hilo_busy_o} !== 2'b10) begin
            n_fail++; $display("FAIL div_release: got accept=%b busy=%b want accept=1 busy=0", opcode_accept_o, hilo_busy_o); end
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_rd_idx_o, writeback_value_o} !== {1'b1, 5'd7, 32'h3}) begin
            n_fail++; $display("FAIL div_mflo: got v=%b rd=%0d val=%h want v=1 rd=7 val=3", writeback_valid_o, writeback_rd_idx_o, writeback_value_o); end
        tick();
    endtask

    task automatic test_spurious_div();
        drive_op(1'b1, F_MULTU, 5'd0, 32'h0);
        tick();
        drive_op(1'b1, F_MFLO, 5'd4, 32'h0);
        drive_wb(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 32'h0, 32'h0);
        tick();
        drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++; if ({opcode_accept_o, hilo_busy_o} !== 2'b01) begin
            n_fail++; $display("FAIL spurious_div: got accept=%b busy=%b want accept=0 busy=1", opcode_accept_o, hilo_busy_o); end
        drive_wb(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h6);
        tick();
        drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        drive_op(1'b1, F_MFHI, 5'd5, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_value_o} !== {1'b1, 32'h6}) begin
            n_fail++; $display("FAIL mul_mflo: got v=%b val=%h want v=1 val=6", writeback_valid_o, writeback_value_o); end
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_value_o} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL mul_mfhi: got v=%b val=%h want v=1 val=0", writeback_valid_o, writeback_value_o); end
        tick();
    endtask

    task automatic test_mtlo_stray_mul();
        drive_op(1'b1, F_MTLO, 5'd0, 32'hAA);
        drive_wb(1'b0, 32'h0, 32'h0, 1'b1, 32'h77, 32'h55);
        tick();
        drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        drive_op(1'b1, F_MFLO, 5'd1, 32'h0);
        tick();
        drive_op(1'b1, F_MFHI, 5'd2, 32'h0);
        n_checks++; if (writeback_value_o !== 32'hAA) begin n_fail++; $display("FAIL mtlo_wins: got %h want 000000aa", writeback_value_o); end
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_rd_idx_o, writeback_value_o} !== {1'b1, 5'd2, 32'h77}) begin
            n_fail++; $display("FAIL stray_mul_hi: got v=%b rd=%0d val=%h want v=1 rd=2 val=77", writeback_valid_o, writeback_rd_idx_o, writeback_value_o); end
        tick();
    endtask

    task automatic test_addu_in_wait();
        drive_op(1'b1, F_DIVU, 5'd0, 32'h0);
        tick();
        drive_op(1'b1, F_ADDU, 5'd8, 32'h0);
        #1;
        n_checks++; if (opcode_accept_o !== 1'b1) begin n_fail++; $display("FAIL addu_accept: got %b want 1", opcode_accept_o); end
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        n_checks++; if ({writeback_valid_o, hilo_busy_o} !== 2'b01) begin
            n_fail++; $display("FAIL addu_no_effect: got wbv=%b busy=%b want wbv=0 busy=1", writeback_valid_o, hilo_busy_o); end
    endtask

    task automatic test_async_reset();
        drive_op(1'b1, F_MFHI, 5'd6, 32'h0);
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++; if ({opcode_accept_o, hilo_busy_o, writeback_valid_o} !== 3'b100) begin
            n_fail++; $display("FAIL async_reset: got accept=%b busy=%b wbv=%b want 1,0,0", opcode_accept_o, hilo_busy_o, writeback_valid_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_op(1'b1, F_MFLO, 5'd6, 32'h0);
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        drive_wb(1'b1, 32'h11, 32'h22, 1'b0, 32'h0, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_value_o} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL reset_lo_cleared: got v=%b val=%h want v=1 val=0", writeback_valid_o, writeback_value_o); end
        tick();
        drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        drive_op(1'b1, F_MFHI, 5'd6, 32'h0);
        tick();
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        n_checks++; if ({writeback_valid_o, writeback_value_o} !== {1'b1, 32'h11}) begin
            n_fail++; $display("FAIL idle_div_wb: got v=%b val=%h want v=1 val=11", writeback_valid_o, writeback_value_o); end
        tick();
    endtask

    task automatic test_random(input int cycles);
        logic [5:0] funcs [10];
        funcs = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_ADDU, 6'h10};
        for (int c = 0; c < cycles; c++) begin
            logic [31:0] r;
            int          k;
            n_checks++;
            if ({writeback_valid_o, hilo_busy_o} !== {m_wbv, m_pend != 0} ||
                {writeback_rd_idx_o, writeback_value_o} !== {m_rd, m_val}) begin
                n_fail++;
                $display("FAIL rand_outputs @%0d: got v=%b busy=%b rd=%0d val=%h want v=%b busy=%b rd=%0d val=%h",
                         c, writeback_valid_o, hilo_busy_o, writeback_rd_idx_o, writeback_value_o,
                         m_wbv, m_pend != 0, m_rd, m_val);
            end
            k = $urandom_range(9);
            drive_op($urandom_range(3) != 0, funcs[k], 5'($urandom()), $urandom());
            if (k == 9) begin
                r = opcode_opcode_i;
                r[31:26] = 6'h23;
                opcode_opcode_i = r;
            end
            drive_wb($urandom_range(5) == 0, $urandom(), $urandom(), $urandom_range(5) == 0, $urandom(), $urandom());
            #1;
            n_checks++;
            if (opcode_accept_o !== exp_accept()) begin
                n_fail++; $display("FAIL rand_accept @%0d: got %b want %b", c, opcode_accept_o, exp_accept());
            end
            tick();
        end
        drive_op(1'b0, 6'h0, 5'd0, 32'h0);
        drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_mthi_mfhi();
        test_div_stall();
        test_spurious_div();
        test_mtlo_stray_mul();
        test_addu_in_wait();
        test_async_reset();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
